fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO, the next-generation replacement for the fixed 8x8 FIFO. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in one clock domain and is the default buffering primitive for new datapath blocks.

## Interface
- DATA_WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- rd_en  input  1  read/pop request
- clr_err  input  1  synchronous clear of overflow/underflow
- data_out  output  DATA_WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH
- count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Reset (async assert, release synchronous to clk): pointers 0, count 0, data_out 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0. Memory contents are not reset.
- Write accepted iff wr_en && !full, using the pre-edge flags. Read accepted iff rd_en && !empty, using the pre-edge flags.
- Read and write both accepted in the same cycle: count unchanged, both pointers advance.
- Write while full: no pointer change, data is dropped, overflow is set. This holds even if a read is accepted in the same cycle (no pass-through).
- Read while empty: no pointer change, data_out holds its value, underflow is set. A simultaneous write is still accepted.
- overflow and underflow remain set until clr_err is sampled high or rst asserts. If clr_err and a new error coincide in the same cycle, the error wins (flag stays 1).
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. full = MSBs differ and the lower bits are equal; empty = pointers equal. count = wr_ptr - rd_ptr, modulo width.
- FWFT=0: on an accepted read, data_out is loaded from mem[rd_ptr] at that edge. Otherwise data_out holds.
- FWFT=1: data_out = mem[rd_ptr] continuously. It is valid whenever empty=0 and undefined-but-stable when empty. rd_en pops the head.

## Timing
- All flags and count reflect state after each edge. They are derived from registered pointers with no combinational path from wr_en/rd_en.
- Write-to-empty-deassert: 1 cycle.
- FWFT=0 read latency: data_out is valid 1 cycle after the rd_en edge.
- FWFT=1: a written word appears on data_out 1 cycle after the write edge, when empty drops.
- Full-to-not-full after an accepted read: 1 cycle.
- Reset mid-operation: all outputs take reset values immediately and asynchronously. The first write after reset is stored in entry 0.

## Structure
- Package fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1
  - typedef enum for the read mode (MODE_STD, MODE_FWFT), with FWFT mapped from it
- Sub-module fifo_mem: simple dual-port RAM, DATA_WIDTH x DEPTH, synchronous write and asynchronous read, no reset.
- Parent fifo_param contains the pointers, count, flag logic, error flags and, for FWFT=0, the data_out register.
- Elaboration-time assertions:
  - DEPTH is a power of two
  - AE_THRESH < AF_THRESH <= DEPTH

## Test plan
- DEPTH=8, FWFT=0: write 0x11..0x18 in 8 cycles -> full=1 and count=8 after the 8th edge; almost_full first rises at count=6. Then read 8 -> data_out 0x11..0x18 in order, each 1 cycle after its rd_en edge; empty=1 at the end.
- Overflow: with the FIFO full, write 0xAA -> overflow=1, count stays 8, 0xAA is never read back. Pulse clr_err -> overflow=0 on the next edge.
- Underflow: FIFO empty, rd_en=1 and wr_en=1 with 0x5C in the same cycle -> underflow=1, count=1, a subsequent read returns 0x5C.
- Simultaneous: with count=4, assert rd_en and wr_en together for 20 cycles with incrementing data -> count stays 4, output sequence is continuous. This exercises pointer wrap twice.
- FWFT=1: write 0x3C -> data_out=0x3C one cycle later with no rd_en. Write 0x3D, then rd_en -> data_out=0x3D on the next cycle.
- Assert rst mid-burst at count=5 -> all outputs take reset values immediately. Then write 0x01, read -> data_out=0x01.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
// Latency: none (package only).
// Backpressure: not applicable.
package fifo_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } read_mode_e;

    // One extra pointer bit separates a full FIFO from an empty one.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
// Latency: a write is visible on rd_data the cycle after its edge.
// Backpressure: none; the caller gates wr_en.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with thresholds, occupancy count, sticky errors and optional FWFT.
// Latency: flags 1 cycle after a write/read edge; FWFT=0 data_out 1 cycle after rd_en edge.
// Backpressure: writes while full and reads while empty are dropped and flagged, never stalled.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int                PW    = ptr_w(DEPTH);
    localparam int                AW    = PW - 1;
    localparam read_mode_e        MODE  = (FWFT != 0) ? MODE_FWFT : MODE_STD;
    localparam logic [PW-1:0]     AF_TH = PW'(AF_THRESH);
    localparam logic [PW-1:0]     AE_TH = PW'(AE_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
        $error("fifo_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd;

    // Flags come only from registered pointers, so no path from wr_en/rd_en.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{(PW-1){1'b0}}, wr_acc};
        rd_ptr_d    = rd_ptr_q + {{(PW-1){1'b0}}, rd_acc};
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (mem_rd)
    );

    if (MODE == MODE_FWFT) begin : g_fwft
        // Masking while empty keeps the output at zero out of reset instead of stale RAM.
        assign data_out = empty ? '0 : mem_rd;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) begin
                dout_d = mem_rd;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a DEPTH=8 standard-read instance and a DEPTH=8 FWFT instance.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       wr_en_f = 1'b0, rd_en_f = 1'b0, clr_err_f = 1'b0;
    logic [7:0] data_in_f = 8'h00;
    logic [7:0] data_out_f;
    logic       full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
    logic [3:0] count_f;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en_f), .data_in(data_in_f), .rd_en(rd_en_f),
        .clr_err(clr_err_f), .data_out(data_out_f), .full(full_f), .empty(empty_f),
        .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
        .overflow(overflow_f), .underflow(underflow_f)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] obs, exp;
        tick();
        exp = {8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        obs = {data_out, count, full, empty, almost_full, almost_empty, overflow, underflow};
        checks++;
        if (obs !== exp) $display("FAIL reset_std: got %h expected %h", obs, exp);
        else passes++;
        obs = {data_out_f, count_f, full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f};
        checks++;
        if (obs !== exp) $display("FAIL reset_fwft: got %h expected %h", obs, exp);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            data_in = 8'h11 + 8'(i);
            tick();
            checks++;
            if ({count, full, almost_full, empty} !== {4'(i + 1), (i == 7), (i >= 5), 1'b0})
                $display("FAIL fill_%0d: count=%0d full=%b af=%b empty=%b expected count=%0d full=%b af=%b empty=0",
                         i, count, full, almost_full, empty, i + 1, (i == 7), (i >= 5));
            else passes++;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        wr_en   = 1'b1;
        data_in = 8'hAA;
        tick();
        wr_en = 1'b0;
        checks++;
        if ({overflow, count, full} !== {1'b1, 4'd8, 1'b1})
            $display("FAIL overflow_set: ovf=%b count=%0d full=%b expected 1 8 1", overflow, count, full);
        else passes++;
        tick();
        checks++;
        if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", overflow);
        else passes++;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", overflow);
        else passes++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if ({data_out, count, full, almost_empty} !== {8'h11 + 8'(i), 4'(7 - i), 1'b0, (7 - i <= 2)})
                $display("FAIL drain_%0d: data=%h count=%0d full=%b ae=%b expected data=%h count=%0d",
                         i, data_out, count, full, almost_empty, 8'h11 + 8'(i), 7 - i);
            else passes++;
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty);
        else passes++;
    endtask

    task automatic test_underflow();
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'h5C;
        tick();
        wr_en = 1'b0;
        checks++;
        if ({underflow, count, empty, data_out} !== {1'b1, 4'd1, 1'b0, 8'h18})
            $display("FAIL underflow_set: unf=%b count=%0d empty=%b data=%h expected 1 1 0 18",
                     underflow, count, empty, data_out);
        else passes++;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({data_out, count, empty} !== {8'h5C, 4'd0, 1'b1})
            $display("FAIL underflow_read: data=%h count=%0d empty=%b expected 5c 0 1", data_out, count, empty);
        else passes++;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", underflow);
        else passes++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            data_in = 8'h20 + 8'(i);
            tick();
        end
        checks++;
        if (count !== 4'd4) $display("FAIL b2b_prefill: count=%0d expected 4", count);
        else passes++;
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 8'h24 + 8'(i);
            tick();
            checks++;
            if ({count, data_out} !== {4'd4, 8'h20 + 8'(i)})
                $display("FAIL b2b_%0d: count=%0d data=%h expected count=4 data=%h",
                         i, count, data_out, 8'h20 + 8'(i));
            else passes++;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (data_out !== 8'h34 + 8'(i))
                $display("FAIL b2b_tail_%0d: data=%h expected %h", i, data_out, 8'h34 + 8'(i));
            else passes++;
        end
        rd_en = 1'b0;
        checks++;
        if ({empty, overflow, underflow} !== 3'b100)
            $display("FAIL b2b_end: empty=%b ovf=%b unf=%b expected 1 0 0", empty, overflow, underflow);
        else passes++;
    endtask

    task automatic test_fwft();
        wr_en_f   = 1'b1;
        data_in_f = 8'h3C;
        tick();
        checks++;
        if ({data_out_f, empty_f} !== {8'h3C, 1'b0})
            $display("FAIL fwft_first: data=%h empty=%b expected 3c 0", data_out_f, empty_f);
        else passes++;
        data_in_f = 8'h3D;
        tick();
        wr_en_f = 1'b0;
        checks++;
        if ({data_out_f, count_f} !== {8'h3C, 4'd2})
            $display("FAIL fwft_hold: data=%h count=%0d expected 3c 2", data_out_f, count_f);
        else passes++;
        rd_en_f = 1'b1;
        tick();
        rd_en_f = 1'b0;
        checks++;
        if ({data_out_f, count_f} !== {8'h3D, 4'd1})
            $display("FAIL fwft_pop: data=%h count=%0d expected 3d 1", data_out_f, count_f);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [17:0] obs, exp;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            data_in = 8'h40 + 8'(i);
            tick();
        end
        checks++;
        if (count !== 4'd5) $display("FAIL rstmid_pre: count=%0d expected 5", count);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        wr_en = 1'b0;
        exp = {8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        obs = {data_out, count, full, empty, almost_full, almost_empty, overflow, underflow};
        checks++;
        if (obs !== exp) $display("FAIL rstmid_async: got %h expected %h", obs, exp);
        else passes++;
        tick();
        rst     = 1'b0;
        wr_en   = 1'b1;
        data_in = 8'h01;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({data_out, count} !== {8'h01, 4'd0})
            $display("FAIL rstmid_first: data=%h count=%0d expected 01 0", data_out, count);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
